// File: rtl/vx_cache_rsp_merge_pkg.sv
// Shared definitions for the cache response merge path: select-width helper,
// perf counter width and the lane skid buffer state encoding.
package vx_cache_rsp_merge_pkg;

  localparam int PERF_CTR_BITS = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_e;

  function automatic int unsigned req_sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_cache_rsp_merge_if.sv
// Bank-side and core-side response buses of the merge block.
// The merge block sees the slave view; the bank/core side sees the master view.
interface vx_cache_rsp_merge_if #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int NUM_PORTS = 1,
  parameter int WORD_SIZE = 4,
  parameter int TAG_WIDTH = 3
);
  import vx_cache_rsp_merge_pkg::*;

  localparam int RSW = req_sel_width(NUM_REQS);
  localparam int WW  = WORD_SIZE * 8;

  logic [NUM_BANKS-1:0]                                 per_bank_core_rsp_valid;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]                  per_bank_core_rsp_pmask;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][RSW-1:0]         per_bank_core_rsp_idx;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][WW-1:0]          per_bank_core_rsp_data;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0][TAG_WIDTH-1:0]   per_bank_core_rsp_tag;
  logic [NUM_BANKS-1:0]                                 per_bank_core_rsp_ready;

  logic [NUM_REQS-1:0]                                  core_rsp_valid;
  logic [NUM_REQS-1:0][WW-1:0]                          core_rsp_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]                   core_rsp_tag;
  logic [NUM_REQS-1:0]                                  core_rsp_ready;

  modport master (
    output per_bank_core_rsp_valid, per_bank_core_rsp_pmask, per_bank_core_rsp_idx,
    output per_bank_core_rsp_data, per_bank_core_rsp_tag,
    input  per_bank_core_rsp_ready,
    input  core_rsp_valid, core_rsp_data, core_rsp_tag,
    output core_rsp_ready
  );

  modport slave (
    input  per_bank_core_rsp_valid, per_bank_core_rsp_pmask, per_bank_core_rsp_idx,
    input  per_bank_core_rsp_data, per_bank_core_rsp_tag,
    output per_bank_core_rsp_ready,
    output core_rsp_valid, core_rsp_data, core_rsp_tag,
    input  core_rsp_ready
  );

endinterface

// File: rtl/vx_cache_rsp_merge_skid_buf.sv
// Two-entry lane buffer with registered valid/data; head register drives the output.
// full is purely state-based so upstream readiness never sees the downstream ready.
module vx_cache_rsp_merge_skid_buf
  import vx_cache_rsp_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 35
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  ready
);

  skid_state_e           state, state_n;
  logic [DATA_WIDTH-1:0] head, head_n;
  logic [DATA_WIDTH-1:0] tail, tail_n;
  logic                  pop;

  assign valid = (state != SKID_EMPTY);
  assign full  = (state == SKID_FULL);
  assign data  = head;
  assign pop   = valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SKID_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      tail  <= tail_n;
    end
  end

  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    unique case (state)
      SKID_EMPTY: begin
        if (push) begin
          head_n  = push_data;
          state_n = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_n = push_data;
        end else if (push) begin
          tail_n  = push_data;
          state_n = SKID_FULL;
        end else if (pop) begin
          state_n = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // pop frees the head slot first, so a simultaneous push lands in the tail
        if (pop) begin
          head_n = tail;
          if (push) tail_n = push_data;
          else      state_n = SKID_ONE;
        end
      end
      default: state_n = SKID_EMPTY;
    endcase
  end

endmodule

// File: rtl/vx_cache_rsp_merge.sv
// Merges per-bank core responses onto core response lanes with a shared rotating
// bank priority and all-or-nothing bank firing. Optional RSP_MERGE_PERF_EN adds a stall counter.
module vx_cache_rsp_merge
  import vx_cache_rsp_merge_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int NUM_PORTS = 1,
  parameter int WORD_SIZE = 4,
  parameter int TAG_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
`ifdef RSP_MERGE_PERF_EN
  output logic [PERF_CTR_BITS-1:0] bank_rsp_stalls,
`endif
  vx_cache_rsp_merge_if.slave bus
);

  localparam int RSW = req_sel_width(NUM_REQS);
  localparam int BSW = req_sel_width(NUM_BANKS);
  localparam int PSW = req_sel_width(NUM_PORTS);
  localparam int WW  = WORD_SIZE * 8;
  localparam int DW  = WW + TAG_WIDTH;

  logic [BSW-1:0]                 prio_ptr, prio_ptr_n;
  logic [NUM_REQS-1:0]            grant_any;
  logic [NUM_REQS-1:0][BSW-1:0]   grant_bank;
  logic [NUM_REQS-1:0][PSW-1:0]   grant_port;
  logic [NUM_BANKS-1:0]           fire;
  logic [NUM_REQS-1:0]            lane_full;
  logic [NUM_REQS-1:0]            push;
  logic [NUM_REQS-1:0][DW-1:0]    push_data;
  logic [NUM_REQS-1:0][DW-1:0]    lane_data;
  logic                           idx_conflict;

  // Per lane: first bank in rotating order with an active port targeting it
  always_comb begin
    int unsigned b;
    grant_any  = '0;
    grant_bank = '0;
    grant_port = '0;
    b = 0;
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
        b = (32'(prio_ptr) + k) % NUM_BANKS;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (!grant_any[r] && bus.per_bank_core_rsp_valid[b]
              && bus.per_bank_core_rsp_pmask[b][p]
              && bus.per_bank_core_rsp_idx[b][p] == RSW'(r)) begin
            grant_any[r]  = 1'b1;
            grant_bank[r] = BSW'(b);
            grant_port[r] = PSW'(p);
          end
        end
      end
    end
  end

  always_comb begin
    logic           ok;
    logic [RSW-1:0] r;
    fire = '0;
    ok   = 1'b0;
    r    = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      ok = bus.per_bank_core_rsp_valid[b];
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r = bus.per_bank_core_rsp_idx[b][p];
        if (bus.per_bank_core_rsp_pmask[b][p]
            && !(grant_any[r] && grant_bank[r] == BSW'(b) && !lane_full[r]))
          ok = 1'b0;
      end
      fire[b] = ok;
    end
  end

  assign bus.per_bank_core_rsp_ready = fire;

  always_comb begin
    push      = '0;
    push_data = '0;
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      push[r]      = grant_any[r] && fire[grant_bank[r]];
      push_data[r] = {bus.per_bank_core_rsp_data[grant_bank[r]][grant_port[r]],
                      bus.per_bank_core_rsp_tag[grant_bank[r]][grant_port[r]]};
    end
  end

  always_comb begin
    logic        found;
    int unsigned b;
    prio_ptr_n = prio_ptr;
    found      = 1'b0;
    b          = 0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      b = (32'(prio_ptr) + k) % NUM_BANKS;
      if (!found && fire[b]) begin
        found      = 1'b1;
        prio_ptr_n = BSW'((b + 1) % NUM_BANKS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) prio_ptr <= '0;
    else       prio_ptr <= prio_ptr_n;
  end

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_lane
    vx_cache_rsp_merge_skid_buf #(
      .DATA_WIDTH(DW)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (push[r]),
      .push_data (push_data[r]),
      .full      (lane_full[r]),
      .valid     (bus.core_rsp_valid[r]),
      .data      (lane_data[r]),
      .ready     (bus.core_rsp_ready[r])
    );
    assign bus.core_rsp_data[r] = lane_data[r][DW-1:TAG_WIDTH];
    assign bus.core_rsp_tag[r]  = lane_data[r][TAG_WIDTH-1:0];
  end

  always_comb begin
    idx_conflict = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      for (int unsigned p = 0; p < NUM_PORTS; p++)
        for (int unsigned q = p + 1; q < NUM_PORTS; q++)
          if (bus.per_bank_core_rsp_valid[b]
              && bus.per_bank_core_rsp_pmask[b][p] && bus.per_bank_core_rsp_pmask[b][q]
              && bus.per_bank_core_rsp_idx[b][p] == bus.per_bank_core_rsp_idx[b][q])
            idx_conflict = 1'b1;
  end

  a_distinct_idx: assert property (@(posedge clk) disable iff (reset) !idx_conflict);

`ifdef RSP_MERGE_PERF_EN
  logic [PERF_CTR_BITS-1:0] stall_cnt, stall_inc;

  always_comb begin
    stall_inc = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      if (bus.per_bank_core_rsp_valid[b] && !fire[b])
        stall_inc = stall_inc + PERF_CTR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else       stall_cnt <= stall_cnt + stall_inc;
  end

  assign bank_rsp_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_vx_cache_rsp_merge.sv
// Directed bench for vx_cache_rsp_merge: one single-port and one dual-port instance.
module tb_vx_cache_rsp_merge;
  import vx_cache_rsp_merge_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  vx_cache_rsp_merge_if #(.NUM_REQS(4), .NUM_BANKS(4), .NUM_PORTS(1), .WORD_SIZE(4), .TAG_WIDTH(3)) b1 ();
  vx_cache_rsp_merge_if #(.NUM_REQS(4), .NUM_BANKS(4), .NUM_PORTS(2), .WORD_SIZE(4), .TAG_WIDTH(3)) b2 ();

`ifdef RSP_MERGE_PERF_EN
  logic [PERF_CTR_BITS-1:0] stalls1, stalls2;
`endif

  vx_cache_rsp_merge #(.NUM_REQS(4), .NUM_BANKS(4), .NUM_PORTS(1), .WORD_SIZE(4), .TAG_WIDTH(3)) dut1 (
    .clk   (clk),
    .reset (reset),
`ifdef RSP_MERGE_PERF_EN
    .bank_rsp_stalls (stalls1),
`endif
    .bus   (b1)
  );

  vx_cache_rsp_merge #(.NUM_REQS(4), .NUM_BANKS(4), .NUM_PORTS(2), .WORD_SIZE(4), .TAG_WIDTH(3)) dut2 (
    .clk   (clk),
    .reset (reset),
`ifdef RSP_MERGE_PERF_EN
    .bank_rsp_stalls (stalls2),
`endif
    .bus   (b2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    b1.per_bank_core_rsp_valid = '0;
    b1.per_bank_core_rsp_pmask = '0;
    b1.per_bank_core_rsp_idx   = '0;
    b1.per_bank_core_rsp_data  = '0;
    b1.per_bank_core_rsp_tag   = '0;
    b1.core_rsp_ready          = '1;
    b2.per_bank_core_rsp_valid = '0;
    b2.per_bank_core_rsp_pmask = '0;
    b2.per_bank_core_rsp_idx   = '0;
    b2.per_bank_core_rsp_data  = '0;
    b2.per_bank_core_rsp_tag   = '0;
    b2.core_rsp_ready          = '1;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_bank1(input int b, input logic [1:0] idx, input logic [31:0] d, input logic [2:0] t);
    b1.per_bank_core_rsp_valid[b]    = 1'b1;
    b1.per_bank_core_rsp_pmask[b]    = 1'b1;
    b1.per_bank_core_rsp_idx[b][0]   = idx;
    b1.per_bank_core_rsp_data[b][0]  = d;
    b1.per_bank_core_rsp_tag[b][0]   = t;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b1;
    step();
    step();
    checks++; if (b1.core_rsp_valid !== 4'b0000) $display("FAIL rst_valid got %b exp %b", b1.core_rsp_valid, 4'b0000); else passes++;
    checks++; if (b1.core_rsp_data !== 128'h0) $display("FAIL rst_data got %h exp 0", b1.core_rsp_data); else passes++;
    checks++; if (b1.core_rsp_tag !== 12'h0) $display("FAIL rst_tag got %h exp 0", b1.core_rsp_tag); else passes++;
    checks++; if (b2.core_rsp_valid !== 4'b0000) $display("FAIL rst_valid2 got %b exp %b", b2.core_rsp_valid, 4'b0000); else passes++;
    reset = 1'b0;
    step();
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0000) $display("FAIL rst_ready got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0000); else passes++;
`ifdef RSP_MERGE_PERF_EN
    checks++; if (stalls1 !== '0) $display("FAIL rst_stalls got %0d exp 0", stalls1); else passes++;
`endif
  endtask

  task automatic test_single;
    do_reset();
    set_bank1(0, 2'd2, 32'hA, 3'd5);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL single_ready got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    idle();
    checks++; if (b1.core_rsp_valid !== 4'b0100) $display("FAIL single_valid got %b exp %b", b1.core_rsp_valid, 4'b0100); else passes++;
    checks++; if (b1.core_rsp_data[2] !== 32'hA) $display("FAIL single_data got %h exp %h", b1.core_rsp_data[2], 32'hA); else passes++;
    checks++; if (b1.core_rsp_tag[2] !== 3'd5) $display("FAIL single_tag got %0d exp 5", b1.core_rsp_tag[2]); else passes++;
    step();
    checks++; if (b1.core_rsp_valid !== 4'b0000) $display("FAIL single_drain got %b exp %b", b1.core_rsp_valid, 4'b0000); else passes++;
  endtask

  task automatic test_conflict;
    do_reset();
    set_bank1(0, 2'd1, 32'h11, 3'd1);
    set_bank1(1, 2'd1, 32'h22, 3'd2);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL conf_ready0 got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    b1.per_bank_core_rsp_valid[0] = 1'b0;
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0010) $display("FAIL conf_ready1 got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0010); else passes++;
    checks++; if (b1.core_rsp_data[1] !== 32'h11) $display("FAIL conf_data0 got %h exp %h", b1.core_rsp_data[1], 32'h11); else passes++;
    step();
    idle();
    checks++; if (b1.core_rsp_data[1] !== 32'h22 || b1.core_rsp_tag[1] !== 3'd2) $display("FAIL conf_data1 got %h/%0d exp 22/2", b1.core_rsp_data[1], b1.core_rsp_tag[1]); else passes++;
    step();
    // pointer is now 2: bank3 precedes bank0
    set_bank1(0, 2'd0, 32'h30, 3'd0);
    set_bank1(3, 2'd0, 32'h33, 3'd3);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b1000) $display("FAIL conf_wrap3 got %b exp %b", b1.per_bank_core_rsp_ready, 4'b1000); else passes++;
    step();
    set_bank1(3, 2'd0, 32'h34, 3'd4);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL conf_wrap0 got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    idle();
    step();
  endtask

  task automatic test_multiport;
    do_reset();
    b2.per_bank_core_rsp_valid[0]    = 1'b1;
    b2.per_bank_core_rsp_pmask[0]    = 2'b01;
    b2.per_bank_core_rsp_idx[0][0]   = 2'd0;
    b2.per_bank_core_rsp_data[0][0]  = 32'h1;
    #1;
    checks++; if (b2.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL mp_setup got %b exp %b", b2.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    idle();
    step();
    b2.per_bank_core_rsp_valid        = 4'b0011;
    b2.per_bank_core_rsp_pmask[0]     = 2'b11;
    b2.per_bank_core_rsp_idx[0][0]    = 2'd0;
    b2.per_bank_core_rsp_idx[0][1]    = 2'd3;
    b2.per_bank_core_rsp_data[0][0]   = 32'hB0;
    b2.per_bank_core_rsp_data[0][1]   = 32'hB3;
    b2.per_bank_core_rsp_tag[0][0]    = 3'd1;
    b2.per_bank_core_rsp_tag[0][1]    = 3'd2;
    b2.per_bank_core_rsp_pmask[1]     = 2'b01;
    b2.per_bank_core_rsp_idx[1][0]    = 2'd3;
    b2.per_bank_core_rsp_data[1][0]   = 32'hC3;
    b2.per_bank_core_rsp_tag[1][0]    = 3'd4;
    #1;
    checks++; if (b2.per_bank_core_rsp_ready !== 4'b0010) $display("FAIL mp_ready0 got %b exp %b", b2.per_bank_core_rsp_ready, 4'b0010); else passes++;
    step();
    b2.per_bank_core_rsp_valid[1] = 1'b0;
    b2.per_bank_core_rsp_pmask[1] = 2'b00;
    #1;
    checks++; if (b2.core_rsp_valid !== 4'b1000) $display("FAIL mp_valid0 got %b exp %b", b2.core_rsp_valid, 4'b1000); else passes++;
    checks++; if (b2.core_rsp_data[3] !== 32'hC3) $display("FAIL mp_data3a got %h exp %h", b2.core_rsp_data[3], 32'hC3); else passes++;
    checks++; if (b2.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL mp_ready1 got %b exp %b", b2.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    idle();
    checks++; if (b2.core_rsp_valid !== 4'b1001) $display("FAIL mp_valid1 got %b exp %b", b2.core_rsp_valid, 4'b1001); else passes++;
    checks++; if (b2.core_rsp_data[0] !== 32'hB0) $display("FAIL mp_data0 got %h exp %h", b2.core_rsp_data[0], 32'hB0); else passes++;
    checks++; if (b2.core_rsp_data[3] !== 32'hB3 || b2.core_rsp_tag[3] !== 3'd2) $display("FAIL mp_data3b got %h/%0d exp b3/2", b2.core_rsp_data[3], b2.core_rsp_tag[3]); else passes++;
    step();
  endtask

  task automatic test_backpressure;
    do_reset();
    b1.core_rsp_ready[0] = 1'b0;
    set_bank1(0, 2'd0, 32'd1, 3'd1);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b1) $display("FAIL bp_push1 got %b exp 1", b1.per_bank_core_rsp_ready[0]); else passes++;
    step();
    set_bank1(0, 2'd0, 32'd2, 3'd2);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b1) $display("FAIL bp_push2 got %b exp 1", b1.per_bank_core_rsp_ready[0]); else passes++;
    step();
    set_bank1(0, 2'd0, 32'd3, 3'd3);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b0) $display("FAIL bp_full got %b exp 0", b1.per_bank_core_rsp_ready[0]); else passes++;
    checks++; if (b1.core_rsp_data[0] !== 32'd1) $display("FAIL bp_head1 got %0d exp 1", b1.core_rsp_data[0]); else passes++;
    step();
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b0 || b1.core_rsp_valid[0] !== 1'b1) $display("FAIL bp_hold got rdy %b vld %b exp 0 1", b1.per_bank_core_rsp_ready[0], b1.core_rsp_valid[0]); else passes++;
    checks++; if (b1.core_rsp_data[0] !== 32'd1) $display("FAIL bp_held1 got %0d exp 1", b1.core_rsp_data[0]); else passes++;
    b1.core_rsp_ready[0] = 1'b1;
    #1;
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b0) $display("FAIL bp_nocomb got %b exp 0", b1.per_bank_core_rsp_ready[0]); else passes++;
    step();
    checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b1) $display("FAIL bp_push3 got %b exp 1", b1.per_bank_core_rsp_ready[0]); else passes++;
    checks++; if (b1.core_rsp_data[0] !== 32'd2) $display("FAIL bp_head2 got %0d exp 2", b1.core_rsp_data[0]); else passes++;
    step();
    idle();
    checks++; if (b1.core_rsp_data[0] !== 32'd3 || b1.core_rsp_tag[0] !== 3'd3 || b1.core_rsp_valid[0] !== 1'b1) $display("FAIL bp_head3 got %0d/%0d exp 3/3", b1.core_rsp_data[0], b1.core_rsp_tag[0]); else passes++;
    step();
    checks++; if (b1.core_rsp_valid[0] !== 1'b0) $display("FAIL bp_empty got %b exp 0", b1.core_rsp_valid[0]); else passes++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    b1.core_rsp_ready = '0;
    for (int b = 0; b < 4; b++) set_bank1(b, 2'(b), 32'h50 + 32'(b), 3'(b));
    step();
    for (int b = 0; b < 4; b++) set_bank1(b, 2'(b), 32'h60 + 32'(b), 3'(b));
    step();
    idle();
    b1.core_rsp_ready = '0;
    checks++; if (b1.core_rsp_valid !== 4'b1111) $display("FAIL rm_full got %b exp %b", b1.core_rsp_valid, 4'b1111); else passes++;
    checks++; if (b1.core_rsp_data[3] !== 32'h53) $display("FAIL rm_head got %h exp %h", b1.core_rsp_data[3], 32'h53); else passes++;
    reset = 1'b1;
    idle();
    step();
    checks++; if (b1.core_rsp_valid !== 4'b0000) $display("FAIL rm_valid got %b exp %b", b1.core_rsp_valid, 4'b0000); else passes++;
    checks++; if (b1.core_rsp_data !== 128'h0 || b1.core_rsp_tag !== 12'h0) $display("FAIL rm_stale got %h/%h exp 0/0", b1.core_rsp_data, b1.core_rsp_tag); else passes++;
    reset = 1'b0;
    // pointer was 2 before reset; bank0 must win only if it returned to 0
    set_bank1(0, 2'd0, 32'h70, 3'd0);
    set_bank1(2, 2'd0, 32'h72, 3'd2);
    #1;
    checks++; if (b1.per_bank_core_rsp_ready !== 4'b0001) $display("FAIL rm_ptr got %b exp %b", b1.per_bank_core_rsp_ready, 4'b0001); else passes++;
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_bank1(0, 2'd0, 32'h80 + 32'(i), 3'(i));
      #1;
      checks++; if (b1.per_bank_core_rsp_ready[0] !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, b1.per_bank_core_rsp_ready[0]); else passes++;
      step();
      checks++; if (b1.core_rsp_valid[0] !== 1'b1 || b1.core_rsp_data[0] !== 32'h80 + 32'(i)) $display("FAIL b2b_data%0d got %h exp %h", i, b1.core_rsp_data[0], 32'h80 + 32'(i)); else passes++;
    end
    idle();
    step();
    checks++; if (b1.core_rsp_valid !== 4'b0000) $display("FAIL b2b_drain got %b exp %b", b1.core_rsp_valid, 4'b0000); else passes++;
  endtask

`ifdef RSP_MERGE_PERF_EN
  task automatic test_perf;
    do_reset();
    b1.core_rsp_ready[0] = 1'b0;
    set_bank1(0, 2'd0, 32'h1, 3'd1);
    repeat (6) step();
    idle();
    checks++; if (stalls1 !== PERF_CTR_BITS'(4)) $display("FAIL perf_stalls got %0d exp 4", stalls1); else passes++;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_single();
    test_conflict();
    test_multiport();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef RSP_MERGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
